rule_readback: RTL and testbench

Read-back decoder for fracTCAM rule storage: the inverse of the rule update path. Given a slice and a rule ID (0–7), it sweeps all 32 LUTRAM addresses of every 5-bit key group and samples the stored match bits. From those bits it reconstructs the ternary rule as a key/mask pair, and flags rules whose stored pattern is empty or not a ternary cube. It sits beside the update logic on the management side of the TCAM and shares the per-group address bus with it through an external mux owned by the top level.

---
 rtl/rule_readback_pkg.sv | 10 +
 rtl/rule_readback_group_decoder.sv | 38 +++
 rtl/rule_readback.sv | 107 ++++++++++
 tb/tb_rule_readback.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rule_readback_pkg.sv
// rule_readback_pkg: shared constants, FSM state type and popcount helper for the rule read-back decoder
package rule_readback_pkg;
  localparam int LUT_AW = 5;
  localparam int RULES_PER_SLICE = 8;
  localparam int SWEEP_LEN = 32;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;
  function automatic logic [2:0] popcount5(input logic [4:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]) + 3'(v[4]);
  endfunction
endpackage

// File: rtl/rule_readback_group_decoder.sv
// group_decoder: per-group accumulator that rebuilds a 5-bit ternary cube from the sampled match addresses
//   wclk, reset (async active-low), clr (restart accumulation), hit (sampled match bit is set),
//   addr (address the hit belongs to), key/mask (recovered cube), ok (group is a non-empty cube)
module group_decoder
  import rule_readback_pkg::*;
(
  input  logic              wclk,
  input  logic              reset,
  input  logic              clr,
  input  logic              hit,
  input  logic [LUT_AW-1:0] addr,
  output logic [LUT_AW-1:0] key,
  output logic [LUT_AW-1:0] mask,
  output logic              ok
);
  logic [LUT_AW-1:0] and_acc, or_acc, dc;
  logic [5:0] hits;
  always_ff @(posedge wclk or negedge reset) begin
    if (!reset) begin
      and_acc <= '1;
      or_acc  <= '0;
      hits    <= '0;
    end else if (clr) begin
      and_acc <= '1;
      or_acc  <= '0;
      hits    <= '0;
    end else if (hit) begin
      and_acc <= and_acc & addr;
      or_acc  <= or_acc | addr;
      hits    <= hits == 6'(SWEEP_LEN) ? hits : hits + 6'd1;
    end
  end
  // bits seen both as 0 and 1 are don't-cares; a true cube has exactly 2^|dc| members
  assign dc   = and_acc ^ or_acc;
  assign key  = hits == '0 ? '0 : and_acc & ~dc;
  assign mask = hits == '0 ? '0 : dc;
  assign ok   = hits != '0 && hits == (6'd1 << popcount5(dc));
endmodule

// File: rtl/rule_readback.sv
// rule_readback: sweeps all LUTRAM addresses of a slice and reconstructs one stored rule as key/mask
//   wclk/reset: clock and async active-low reset; start/rd_sel/rule_id: request, slice and rule
//   rd_slice/rd_addr: registered read select and per-group address; rd_data: LUTRAM match bits
//   busy/done: progress and completion pulse; key_out/mask_out/rule_valid: decoded result
module rule_readback
  import rule_readback_pkg::*;
#(
  parameter int D  = 512,
  parameter int W  = 40,
  parameter int SN = 2,
  parameter int RL = 1
) (
  input  logic                wclk,
  input  logic                reset,
  input  logic                start,
  input  logic [SN-1:0]       rd_sel,
  input  logic [2:0]          rule_id,
  output logic [SN-1:0]       rd_slice,
  output logic [W-1:0]        rd_addr,
  input  logic [W*8/5-1:0]    rd_data,
  output logic                busy,
  output logic                done,
  output logic [W-1:0]        key_out,
  output logic [W-1:0]        mask_out,
  output logic                rule_valid
);
  localparam int G = W / LUT_AW;
  if (W % LUT_AW != 0 || RL < 1 || RL > 4 || D % RULES_PER_SLICE != 0) begin : g_bad_cfg
    $error("rule_readback: illegal parameter set");
  end
  state_t state;
  logic [LUT_AW-1:0] cnt;
  logic [2:0] rid;
  logic [RL-1:0] vld;
  logic [LUT_AW-1:0] ap [RL];
  logic [W-1:0] key_c, mask_c;
  logic [G-1:0] ok;
  logic fin, clr;
  // cnt is reused as the drain counter after wrapping past 31
  assign fin = state == DRAIN && cnt == LUT_AW'(RL);
  assign clr = state == IDLE && start;
  always_ff @(posedge wclk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rid        <= '0;
      vld        <= '0;
      for (int i = 0; i < RL; i++) ap[i] <= '0;
      rd_slice   <= '0;
      rd_addr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      key_out    <= '0;
      mask_out   <= '0;
      rule_valid <= 1'b0;
    end else begin
      done   <= fin;
      busy   <= state == SWEEP || (state == DRAIN && !fin);
      vld[0] <= state == SWEEP;
      ap[0]  <= cnt;
      for (int i = 1; i < RL; i++) begin
        vld[i] <= vld[i-1];
        ap[i]  <= ap[i-1];
      end
      case (state)
        IDLE: begin
          rd_addr <= '0;
          if (start) begin
            state    <= SWEEP;
            cnt      <= '0;
            rd_slice <= rd_sel;
            rid      <= rule_id;
          end
        end
        SWEEP: begin
          rd_addr <= {G{cnt}};
          cnt     <= cnt + 1'b1;
          state   <= cnt == LUT_AW'(SWEEP_LEN - 1) ? DRAIN : SWEEP;
        end
        default: begin
          cnt <= cnt + 1'b1;
          if (fin) begin
            state      <= IDLE;
            rd_addr    <= '0;
            key_out    <= key_c;
            mask_out   <= mask_c;
            rule_valid <= &ok;
          end
        end
      endcase
    end
  end
  for (genvar g = 0; g < G; g++) begin : g_grp
    logic [RULES_PER_SLICE-1:0] lane;
    assign lane = rd_data[g*RULES_PER_SLICE +: RULES_PER_SLICE];
    group_decoder u_dec (
      .wclk(wclk),
      .reset(reset),
      .clr(clr),
      .hit(vld[RL-1] & lane[rid]),
      .addr(ap[RL-1]),
      .key(key_c[g*LUT_AW +: LUT_AW]),
      .mask(mask_c[g*LUT_AW +: LUT_AW]),
      .ok(ok[g])
    );
  end
endmodule

// File: tb/tb_rule_readback.sv
// tb_rule_readback: randomized read-back of modelled LUTRAM contents checked against a set-based cube model
module tb_rule_readback;
  localparam int W = 40, SN = 2, DW = W * 8 / 5, G = W / 5;
  logic wclk = 0, reset = 0, start1 = 0, start2 = 0;
  logic [SN-1:0] sel = 0, sl1, sl2, ps2 = 0, sx;
  logic [2:0] rid = 0;
  logic [W-1:0] a1, a2, k1, k2, m1, m2, pa2 = 0, kx, mx, ax;
  logic [DW-1:0] d1 = 0, d2 = 0;
  logic b1, b2, dn1, dn2, v1, v2, bx, dx, vx;
  int who = 1, n_chk = 0, n_fail = 0;
  logic [7:0] mem [4][8][32];
  always #5 wclk = ~wclk;
  rule_readback #(.D(512), .W(W), .SN(SN), .RL(1)) u1 (
    .wclk(wclk), .reset(reset), .start(start1), .rd_sel(sel), .rule_id(rid), .rd_slice(sl1),
    .rd_addr(a1), .rd_data(d1), .busy(b1), .done(dn1), .key_out(k1), .mask_out(m1), .rule_valid(v1));
  rule_readback #(.D(512), .W(W), .SN(SN), .RL(2)) u2 (
    .wclk(wclk), .reset(reset), .start(start2), .rd_sel(sel), .rule_id(rid), .rd_slice(sl2),
    .rd_addr(a2), .rd_data(d2), .busy(b2), .done(dn2), .key_out(k2), .mask_out(m2), .rule_valid(v2));
  assign bx = who == 2 ? b2 : b1;
  assign dx = who == 2 ? dn2 : dn1;
  assign vx = who == 2 ? v2 : v1;
  assign kx = who == 2 ? k2 : k1;
  assign mx = who == 2 ? m2 : m1;
  assign ax = who == 2 ? a2 : a1;
  assign sx = who == 2 ? sl2 : sl1;
  function automatic logic [DW-1:0] lut(input logic [SN-1:0] s, input logic [W-1:0] a);
    logic [DW-1:0] d;
    for (int g = 0; g < G; g++) d[8*g +: 8] = mem[s][g][a[5*g +: 5]];
    return d;
  endfunction
  // RL=1: data follows the address within the cycle; RL=2: one extra cycle of delay
  always @(negedge wclk) begin
    d1  <= lut(sl1, a1);
    d2  <= lut(ps2, pa2);
    pa2 <= a2;
    ps2 <= sl2;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic write_rule(input int s, input int r, input logic [W-1:0] k, input logic [W-1:0] m);
    for (int g = 0; g < G; g++)
      for (int a = 0; a < 32; a++)
        mem[s][g][a][r] = ((5'(a) & ~m[5*g +: 5]) == (k[5*g +: 5] & ~m[5*g +: 5]));
  endtask
  task automatic set_group(input int s, input int r, input int g, input logic [31:0] bm);
    for (int a = 0; a < 32; a++) mem[s][g][a][r] = bm[a];
  endtask
  // a group is a cube iff its member set equals {x : x&~mask == key}, mask = bits seen both ways
  task automatic model(input int s, input int r, output logic [W-1:0] key, output logic [W-1:0] mask,
                       output logic ok);
    key = '0; mask = '0; ok = 1'b1;
    for (int g = 0; g < G; g++) begin
      logic [4:0] s1, s0, k, m;
      int cnt;
      s1 = '0; s0 = '0; cnt = 0;
      for (int a = 0; a < 32; a++)
        if (mem[s][g][a][r]) begin cnt++; s1 |= 5'(a); s0 |= ~5'(a); end
      if (cnt == 0) ok = 1'b0;
      else begin
        m = s1 & s0; k = s1 & ~s0;
        for (int a = 0; a < 32; a++)
          if (mem[s][g][a][r] != ((5'(a) & ~m) == k)) ok = 1'b0;
        key[5*g +: 5] = k; mask[5*g +: 5] = m;
      end
    end
  endtask
  task automatic run(input int w, input int s, input int r, input int pulse_at, input string tag);
    int n, lat;
    logic [W-1:0] ek, em;
    logic ev;
    n = 0; lat = w == 2 ? 35 : 34; who = w;
    @(negedge wclk);
    sel = SN'(s); rid = 3'(r);
    if (w == 2) start2 = 1; else start1 = 1;
    @(posedge wclk); #1;
    start1 = 0; start2 = 0;
    chk({tag, "_busy_e0"}, 64'(bx), 64'd0);
    do begin
      @(posedge wclk); #1;
      n++;
      if (n == 1) chk({tag, "_busy_e1"}, 64'(bx), 64'd1);
      if (n == pulse_at) begin
        sel = ~SN'(s);
        if (w == 2) start2 = 1; else start1 = 1;
      end else if (n == pulse_at + 1) begin
        start1 = 0; start2 = 0;
      end
    end while (!dx && n < 100);
    model(s, r, ek, em, ev);
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_key"}, 64'(kx), 64'(ek));
    chk({tag, "_mask"}, 64'(mx), 64'(em));
    chk({tag, "_valid"}, 64'(vx), 64'(ev));
    chk({tag, "_busy_done"}, 64'(bx), 64'd0);
    chk({tag, "_slice"}, 64'(sx), 64'(s));
    chk({tag, "_addr_idle"}, 64'(ax), 64'd0);
  endtask
  task automatic chk_reset_vals(input string tag);
    for (int w = 1; w <= 2; w++) begin
      who = w; #1;
      chk({tag, "_busy"}, 64'(bx), 64'd0);
      chk({tag, "_done"}, 64'(dx), 64'd0);
      chk({tag, "_addr"}, 64'(ax), 64'd0);
      chk({tag, "_slice"}, 64'(sx), 64'd0);
      chk({tag, "_key"}, 64'(kx), 64'd0);
      chk({tag, "_mask"}, 64'(mx), 64'd0);
      chk({tag, "_valid"}, 64'(vx), 64'd0);
    end
  endtask
  initial begin
    logic [W-1:0] k, m;
    int dones;
    for (int s = 0; s < 4; s++)
      for (int g = 0; g < G; g++)
        for (int a = 0; a < 32; a++) mem[s][g][a] = 8'($urandom);
    repeat (3) @(posedge wclk);
    chk_reset_vals("reset");
    @(negedge wclk) reset = 1;
    write_rule(1, 5, 40'h12_3456_789A, '0);
    run(1, 1, 5, 0, "exact");
    chk("exact_key_const", 64'(k1), 64'h12_3456_789A);
    chk("exact_valid_const", 64'(v1), 64'd1);
    k = {$urandom, $urandom};
    write_rule(2, 3, {k[39:5], 5'b10001}, {35'd0, 5'b01010});
    run(1, 2, 3, 0, "dc_grp0");
    chk("dc_grp0_key", 64'(k1[4:0]), 64'b10001);
    chk("dc_grp0_mask", 64'(m1[4:0]), 64'b01010);
    chk("dc_grp0_valid", 64'(v1), 64'd1);
    write_rule(0, 6, {$urandom, $urandom}, '0);
    set_group(0, 6, 2, 32'h0000_1008);
    run(1, 0, 6, 0, "noncube");
    chk("noncube_valid", 64'(v1), 64'd0);
    chk("noncube_mask2", 64'(m1[14:10]), 64'b01111);
    write_rule(3, 0, {$urandom, $urandom}, {$urandom, $urandom} & {$urandom, $urandom});
    set_group(3, 0, 4, 32'h0);
    run(1, 3, 0, 0, "empty");
    chk("empty_key4", 64'(k1[24:20]), 64'd0);
    chk("empty_mask4", 64'(m1[24:20]), 64'd0);
    chk("empty_valid", 64'(v1), 64'd0);
    for (int i = 0; i < 6; i++) begin
      int s, r;
      s = int'($urandom_range(0, 3)); r = int'($urandom_range(0, 7));
      k = {$urandom, $urandom};
      m = {$urandom, $urandom} & {$urandom, $urandom};
      write_rule(s, r, k, m);
      if ($urandom_range(0, 1) == 1) set_group(s, r, int'($urandom_range(0, G - 1)), $urandom);
      run(1, s, r, 0, "random");
    end
    who = 1;
    @(negedge wclk);
    sel = 2'd2; rid = 3'd1; start1 = 1;
    @(posedge wclk); #1;
    start1 = 0;
    repeat (17) @(posedge wclk);
    #1;
    chk("mid_addr", 64'(a1), 64'({8{5'd16}}));
    reset = 0;
    chk_reset_vals("abort");
    dones = 0;
    repeat (2) @(posedge wclk);
    @(negedge wclk) reset = 1;
    repeat (40) begin
      @(posedge wclk); #1;
      if (dn1) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    chk("abort_idle_busy", 64'(b1), 64'd0);
    run(1, 2, 1, 0, "after_abort");
    write_rule(1, 2, {$urandom, $urandom}, {$urandom, $urandom} & {$urandom, $urandom});
    run(2, 1, 2, 5, "rl2_pulse");
    write_rule(2, 7, {$urandom, $urandom}, {$urandom, $urandom} & {$urandom, $urandom});
    run(2, 2, 7, 0, "rl2_b2b");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
